// File: rtl/prog_counter_pkg.sv
// ---------------------------------------------------------------------------
// prog_counter_pkg
// Shared definitions for the programmable up/down counter.
//   MODE_*   : encodings of the 2-bit boundary-mode input (11 acts as wrap)
//   state_t  : one-shot run/done state
// ---------------------------------------------------------------------------
package prog_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/count_step_calc.sv
// ---------------------------------------------------------------------------
// count_step_calc
// Combinational next-value calculator for one enabled counting step.
// All arithmetic is carried one bit wider than the counter so that
// carries and borrows are visible.
//   cout      : current counter value
//   incr      : unsigned step size
//   updn      : 1 = up, 0 = down
//   limit     : upper bound of the count range [0, limit]
//   mode      : boundary mode (wrap / saturate / one-shot, 11 = wrap)
//   nxt       : value the counter takes if this step is applied
//   bound     : step produces a terminal-count event
//   wrap_clip : step wrapped or was clipped (sets the sticky overflow)
// ---------------------------------------------------------------------------
module count_step_calc
  import prog_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int INCR_W = 4
) (
  input  logic [WIDTH-1:0]  cout,
  input  logic [INCR_W-1:0] incr,
  input  logic              updn,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              bound,
  output logic              wrap_clip
);

  localparam int EW = WIDTH + 1;

  logic [EW-1:0]    c_ext;
  logic [EW-1:0]    i_ext;
  logic [EW-1:0]    lim_ext;
  logic [EW-1:0]    lim_p1;
  logic [EW-1:0]    sum;
  logic [EW-1:0]    wrap_up;
  logic [EW-1:0]    borrow_amt;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] wrap_dn;
  logic             is_sat;
  logic             is_os;

  assign c_ext      = {1'b0, cout};
  assign i_ext      = EW'(incr);
  assign lim_ext    = {1'b0, limit};
  assign lim_p1     = lim_ext + EW'(1);
  assign sum        = c_ext + i_ext;
  assign wrap_up    = sum - lim_p1;
  // Only meaningful when cout < incr; amount by which the step undershoots.
  assign borrow_amt = i_ext - c_ext;
  assign diff       = cout - WIDTH'(incr);
  // limit - (borrow_amt - 1); borrow_amt never reaches 2**WIDTH because
  // incr is at most WIDTH bits wide.
  assign wrap_dn    = limit - (borrow_amt[WIDTH-1:0] - WIDTH'(1));
  assign is_sat     = (mode == MODE_SAT);
  assign is_os      = (mode == MODE_ONESHOT);

  always_comb begin
    nxt       = cout;
    bound     = 1'b0;
    wrap_clip = 1'b0;
    if (cout > limit) begin
      // Limit was lowered under the running count.
      bound     = 1'b1;
      wrap_clip = 1'b1;
      if (is_sat || is_os) nxt = limit;
      else                 nxt = updn ? '0 : limit;
    end else if (updn) begin
      if (sum > lim_ext) begin
        wrap_clip = 1'b1;
        if (is_sat || is_os) begin
          nxt = limit;
          // Saturate only pulses on arrival; one-shot always finishes here.
          bound = is_os || (cout != limit);
        end else begin
          nxt   = (wrap_up > lim_ext) ? '0 : wrap_up[WIDTH-1:0];
          bound = 1'b1;
        end
      end else begin
        nxt   = sum[WIDTH-1:0];
        bound = (is_sat || is_os) && (sum == lim_ext);
      end
    end else begin
      if (c_ext < i_ext) begin
        wrap_clip = 1'b1;
        if (is_sat || is_os) begin
          nxt   = '0;
          bound = is_os || (cout != '0);
        end else begin
          nxt   = (borrow_amt > lim_p1) ? limit : wrap_dn;
          bound = 1'b1;
        end
      end else begin
        nxt   = diff;
        bound = (is_sat || is_os) && (diff == '0);
      end
    end
  end

endmodule

// File: rtl/prog_updn_counter.sv
// ---------------------------------------------------------------------------
// prog_updn_counter
// Parametrised up/down counter with programmable limit, wrap / saturate /
// one-shot boundary modes, terminal-count pulse and sticky overflow.
//   clk      : clock, all updates on rising edge
//   reset    : synchronous active-low reset
//   enable   : count-step enable
//   updn     : 1 = up, 0 = down
//   preload  : load pl_data (clamped to limit), wins over enable
//   pl_data  : preload value
//   incr     : unsigned step size (0 = hold)
//   mode     : 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   limit    : upper bound of the count range
//   clr_ovf  : clear sticky overflow (a same-cycle set wins)
//   cout     : counter value
//   tc       : one-cycle terminal-count pulse
//   ovf      : sticky wrap/clip flag
//   done     : one-shot has finished
// ---------------------------------------------------------------------------
module prog_updn_counter
  import prog_counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               INCR_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              updn,
  input  logic              preload,
  input  logic [WIDTH-1:0]  pl_data,
  input  logic [INCR_W-1:0] incr,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  cout,
  output logic              tc,
  output logic              ovf,
  output logic              done
);

  state_t           state;
  logic [WIDTH-1:0] nxt;
  logic             bound;
  logic             wrap_clip;
  logic             step_ok;
  logic             reached;

  count_step_calc #(
    .WIDTH  (WIDTH),
    .INCR_W (INCR_W)
  ) u_calc (
    .cout      (cout),
    .incr      (incr),
    .updn      (updn),
    .limit     (limit),
    .mode      (mode),
    .nxt       (nxt),
    .bound     (bound),
    .wrap_clip (wrap_clip)
  );

  assign step_ok = enable && (state == ST_RUN) && (incr != '0);
  // One-shot finishes only on the bound of the counting direction.
  assign reached = updn ? (nxt == limit) : (nxt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cout  <= RESET_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else begin
      tc <= 1'b0;
      if (clr_ovf) ovf <= 1'b0;
      if (preload) begin
        cout  <= (pl_data > limit) ? limit : pl_data;
        state <= ST_RUN;
        done  <= 1'b0;
      end else if ((state == ST_DONE) && (mode != MODE_ONESHOT)) begin
        // Mode moved away from one-shot: resume counting from next edge.
        state <= ST_RUN;
        done  <= 1'b0;
      end else if (step_ok) begin
        cout <= nxt;
        tc   <= bound;
        if (wrap_clip) ovf <= 1'b1;
        if ((mode == MODE_ONESHOT) && bound && reached) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_updn_counter.sv
module tb_prog_updn_counter;

  localparam int WIDTH  = 8;
  localparam int INCR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              updn;
  logic              preload;
  logic [WIDTH-1:0]  pl_data;
  logic [INCR_W-1:0] incr;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  limit;
  logic              clr_ovf;
  logic [WIDTH-1:0]  cout;
  logic              tc;
  logic              ovf;
  logic              done;

  prog_updn_counter #(
    .WIDTH     (WIDTH),
    .INCR_W    (INCR_W),
    .RESET_VAL (8'd0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .updn    (updn),
    .preload (preload),
    .pl_data (pl_data),
    .incr    (incr),
    .mode    (mode),
    .limit   (limit),
    .clr_ovf (clr_ovf),
    .cout    (cout),
    .tc      (tc),
    .ovf     (ovf),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, en, ud, pl, clr;
    int pd, inc, md, lim;
    int ec;
    bit etc, eov, edn;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural reference: plain integer arithmetic on the counting rules.
  int m_cout = 0;
  bit m_tc = 0, m_ovf = 0, m_done = 0;

  task automatic model_edge(input bit rst, en, ud, pl, clr, input int pd, inc, md, lim);
    bit bounded;
    if (!rst) begin
      m_cout = 0; m_tc = 0; m_ovf = 0; m_done = 0;
      return;
    end
    m_tc = 0;
    if (clr) m_ovf = 0;
    if (pl) begin
      m_cout = (pd > lim) ? lim : pd;
      m_done = 0;
      return;
    end
    if (m_done) begin
      if (md != 2) m_done = 0;
      return;
    end
    if (!en || inc == 0) return;
    bounded = (md == 1) || (md == 2);
    if (m_cout > lim) begin
      m_cout = bounded ? lim : (ud ? 0 : lim);
      m_tc = 1; m_ovf = 1;
    end else if (ud) begin
      if (m_cout + inc > lim) begin
        m_ovf = 1;
        if (bounded) begin
          m_tc = (md == 2) || (m_cout != lim);
          m_cout = lim;
        end else begin
          m_cout = m_cout + inc - (lim + 1);
          if (m_cout > lim) m_cout = 0;
          m_tc = 1;
        end
      end else begin
        m_cout = m_cout + inc;
        m_tc = bounded && (m_cout == lim);
      end
    end else begin
      if (m_cout < inc) begin
        m_ovf = 1;
        if (bounded) begin
          m_tc = (md == 2) || (m_cout != 0);
          m_cout = 0;
        end else begin
          m_cout = (inc - m_cout > lim + 1) ? lim : lim - (inc - m_cout - 1);
          m_tc = 1;
        end
      end else begin
        m_cout = m_cout - inc;
        m_tc = bounded && (m_cout == 0);
      end
    end
    if (md == 2 && m_tc && m_cout == (ud ? lim : 0)) m_done = 1;
  endtask

  task automatic r(input bit rst, en, ud, pl, input int pd, inc, md, lim,
                   input bit clr, input int ec, input bit etc, eov, edn);
    vec_t v;
    v.rst = rst; v.en = en; v.ud = ud; v.pl = pl; v.clr = clr;
    v.pd = pd; v.inc = inc; v.md = md; v.lim = lim;
    v.ec = ec; v.etc = etc; v.eov = eov; v.edn = edn;
    vecs.push_back(v);
  endtask

  task automatic drive_edge(input bit rst, en, ud, pl, clr, input int pd, inc, md, lim);
    @(negedge clk);
    reset = rst; enable = en; updn = ud; preload = pl; clr_ovf = clr;
    pl_data = WIDTH'(pd); incr = INCR_W'(inc); mode = 2'(md); limit = WIDTH'(lim);
    @(posedge clk);
    model_edge(rst, en, ud, pl, clr, pd, inc, md, lim);
    #1;
  endtask

  task automatic check(input string name, input int ec, input bit etc, eov, edn);
    total++;
    if (cout !== WIDTH'(ec) || tc !== etc || ovf !== eov || done !== edn) begin
      bad++;
      $display("FAIL %s: got cout=%0d tc=%0b ovf=%0b done=%0b, want cout=%0d tc=%0b ovf=%0b done=%0b",
               name, cout, tc, ovf, done, ec, etc, eov, edn);
    end
  endtask

  initial begin
    int lim_r;
    reset = 0; enable = 0; updn = 1; preload = 0; clr_ovf = 0;
    pl_data = '0; incr = '0; mode = '0; limit = '0;

    // Reset held with preload asserted, then counting 1,2,3.
    for (int k = 0; k < 3; k++) r(0,1,1,1,7,1,0,255,0, 0,0,0,0);
    for (int k = 1; k <= 3; k++) r(1,1,1,0,0,1,0,255,0, k,0,0,0);
    // Wrap up: 8+4 in [0,9] -> 2, then 6; clear ovf.
    r(1,1,1,1,8,4,0,9,0, 8,0,0,0);
    r(1,1,1,0,0,4,0,9,0, 2,1,1,0);
    r(1,1,1,0,0,4,0,9,0, 6,0,1,0);
    r(1,0,1,0,0,4,0,9,1, 6,0,0,0);
    // Wrap down: 1-4 in [0,9] -> 7.
    r(1,0,0,1,1,4,0,9,0, 1,0,0,0);
    r(1,1,0,0,0,4,0,9,0, 7,1,1,0);
    r(1,0,0,0,0,4,0,9,1, 7,0,0,0);
    // Preload clamp, enable low holds, incr=0 holds.
    r(1,0,1,1,200,1,0,99,0, 99,0,0,0);
    r(1,0,1,1,50,1,0,99,0, 50,0,0,0);
    r(1,1,1,0,0,1,0,99,0, 51,0,0,0);
    for (int k = 0; k < 10; k++) r(1,0,1,0,0,1,0,99,0, 51,0,0,0);
    r(1,1,1,0,0,1,0,99,0, 52,0,0,0);
    r(1,1,1,0,0,0,0,99,0, 52,0,0,0);
    // Saturate down.
    r(1,1,0,1,5,4,1,255,0, 5,0,0,0);
    r(1,1,0,0,0,4,1,255,0, 1,0,0,0);
    r(1,1,0,0,0,4,1,255,0, 0,1,1,0);
    r(1,1,0,0,0,4,1,255,0, 0,0,1,0);
    r(1,0,0,0,0,4,1,255,1, 0,0,0,0);
    // One-shot up; 18+4 clips at 20.
    r(1,1,1,1,10,4,2,20,0, 10,0,0,0);
    r(1,1,1,0,0,4,2,20,0, 14,0,0,0);
    r(1,1,1,0,0,4,2,20,0, 18,0,0,0);
    r(1,1,1,0,0,4,2,20,0, 20,1,1,1);
    r(1,1,1,0,0,4,2,20,0, 20,0,1,1);
    r(1,1,1,0,0,4,2,20,0, 20,0,1,1);
    r(1,1,1,1,0,4,2,20,0, 0,0,1,0);
    r(1,1,1,0,0,4,2,20,0, 4,0,1,0);
    r(1,1,1,0,0,4,2,20,0, 8,0,1,0);
    // Leaving one-shot while DONE: one edge back to RUN, then wrap 24 -> 3.
    r(1,1,1,1,18,4,2,20,0, 18,0,1,0);
    r(1,1,1,0,0,4,2,20,0, 20,1,1,1);
    r(1,1,1,0,0,4,0,20,0, 20,0,1,0);
    r(1,1,1,0,0,4,0,20,0, 3,1,1,0);
    // clr_ovf in the same cycle as a wrap: set wins.
    r(1,0,1,1,8,4,0,9,1, 8,0,0,0);
    r(1,1,1,0,0,4,0,9,1, 2,1,1,0);
    // Limit lowered under the count.
    r(1,0,1,1,50,1,0,255,1, 50,0,0,0);
    r(1,1,1,0,0,1,0,3,0, 0,1,1,0);
    // Reset mid-count.
    r(1,1,1,1,100,1,0,255,0, 100,0,1,0);
    r(1,1,1,0,0,1,0,255,0, 101,0,1,0);
    r(0,1,1,0,0,1,0,255,0, 0,0,0,0);

    foreach (vecs[k]) begin
      drive_edge(vecs[k].rst, vecs[k].en, vecs[k].ud, vecs[k].pl, vecs[k].clr,
                 vecs[k].pd, vecs[k].inc, vecs[k].md, vecs[k].lim);
      check($sformatf("vec%0d", k), vecs[k].ec, vecs[k].etc, vecs[k].eov, vecs[k].edn);
    end

    // Randomised run against the reference model.
    lim_r = 200;
    for (int k = 0; k < 3000; k++) begin
      bit rst, en, ud, pl, clr;
      int pd, inc, md;
      if ($urandom_range(31) == 0)
        lim_r = ($urandom_range(1) == 0) ? int'($urandom_range(15)) : int'($urandom_range(255));
      rst = ($urandom_range(127) != 0);
      pl  = ($urandom_range(15) == 0);
      en  = ($urandom_range(3) != 0);
      ud  = $urandom_range(1) == 1;
      clr = ($urandom_range(15) == 0);
      pd  = $urandom_range(255);
      inc = $urandom_range(15);
      md  = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : int'(mode);
      if (k == 0) md = 0;
      drive_edge(rst, en, ud, pl, clr, pd, inc, md, lim_r);
      check($sformatf("rand%0d", k), m_cout, m_tc, m_ovf, m_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
